act_skew_feeder: RTL and testbench

// - Downstream of the activation manager: consumes its 64-bit activation stream (LANES x LANE_W words).
// - Skews lane k by k shift cycles so the systolic array sees a diagonal wavefront.
// - Counts words per pass, drains the skew chain after the last word, then pulses pass_done.

---
 rtl/act_skew_feeder.sv | 132 +++++++++++++
 tb/tb_act_skew_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_skew_feeder.sv
// Skews a LANES-wide activation stream into a diagonal wavefront for a systolic array, then drains and pulses pass_done.
// Optional input-bubble counter is compiled in when ACT_SKEW_BUBBLE_CNT_EN is defined.
module act_skew_feeder #(
  parameter int LANES  = 4,
  parameter int LANE_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic [LEN_W-1:0]        cfg_vec_len,
  output logic                    cfg_busy,
  input  logic                    s_axis_act_tvalid,
  output logic                    s_axis_act_tready,
  input  logic [LANES*LANE_W-1:0] s_axis_act_tdata,
  input  logic                    array_en,
  output logic [LANES*LANE_W-1:0] lane_data,
  output logic [LANES-1:0]        lane_valid,
  output logic                    pass_done,
  output logic [31:0]             bubble_cnt
);
  localparam int FC_W = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] vec_len_q, vec_len_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             start_acc, accept, shift, last_word, flush_end;

  assign start_acc = cfg_start & (state_q == IDLE);
  assign accept    = s_axis_act_tvalid & s_axis_act_tready;
  assign last_word = (word_cnt_q == vec_len_q - LEN_W'(1));
  assign flush_end = (flush_cnt_q == FC_W'(LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = (cfg_vec_len == '0) ? DONE : RUN;
      RUN:     if (accept && last_word) state_d = (LANES == 1) ? DONE : FLUSH;
      FLUSH:   if (shift && flush_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_busy          = (state_q != IDLE);
    pass_done         = (state_q == DONE);
    s_axis_act_tready = array_en & (state_q == RUN);
    shift             = array_en & ((state_q == RUN) | (state_q == FLUSH));
  end

  // word_cnt never wraps: it tops out at vec_len, which fits LEN_W bits.
  always_comb begin
    vec_len_d   = vec_len_q;
    word_cnt_d  = word_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (start_acc) begin
      vec_len_d   = cfg_vec_len;
      word_cnt_d  = '0;
      flush_cnt_d = '0;
    end
    if (accept) word_cnt_d = word_cnt_q + LEN_W'(1);
    if (shift && (state_q == FLUSH)) flush_cnt_d = flush_cnt_q + FC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_len_q   <= '0;
      word_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      vec_len_q   <= vec_len_d;
      word_cnt_q  <= word_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [LANE_W-1:0] dat_q [k+1];
    logic              vld_q [k+1];

    // Lane k is k+1 deep; empty slots carry zero data so bubbles stay aligned across lanes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= k; j++) begin
          dat_q[j] <= '0;
          vld_q[j] <= 1'b0;
        end
      end else if (shift) begin
        dat_q[0] <= accept ? s_axis_act_tdata[k*LANE_W +: LANE_W] : '0;
        vld_q[0] <= accept;
        for (int j = 1; j <= k; j++) begin
          dat_q[j] <= dat_q[j-1];
          vld_q[j] <= vld_q[j-1];
        end
      end
    end

    assign lane_data[k*LANE_W +: LANE_W] = dat_q[k];
    assign lane_valid[k]                 = vld_q[k];
  end

`ifdef ACT_SKEW_BUBBLE_CNT_EN
  logic [31:0] bubble_q, bubble_d;

  always_comb begin
    bubble_d = bubble_q;
    if (start_acc)
      bubble_d = '0;
    else if (shift && (state_q == RUN) && !accept && (bubble_q != 32'hFFFF_FFFF))
      bubble_d = bubble_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_q <= '0;
    else        bubble_q <= bubble_d;
  end

  assign bubble_cnt = bubble_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Bench for act_skew_feeder: cycle table for a basic pass, per-lane scoreboard, and hand sequences for corner cases.
`timescale 1ns/1ps
module tb_act_skew_feeder;
  localparam int LANES  = 4;
  localparam int LANE_W = 16;
  localparam int LEN_W  = 16;
  localparam int DW     = LANES * LANE_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_start;
  logic [LEN_W-1:0] cfg_vec_len;
  logic             cfg_busy;
  logic             s_axis_act_tvalid;
  logic             s_axis_act_tready;
  logic [DW-1:0]    s_axis_act_tdata;
  logic             array_en;
  logic [DW-1:0]    lane_data;
  logic [LANES-1:0] lane_valid;
  logic             pass_done;
  logic [31:0]      bubble_cnt;

  act_skew_feeder #(.LANES(LANES), .LANE_W(LANE_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_vec_len(cfg_vec_len),
    .cfg_busy(cfg_busy), .s_axis_act_tvalid(s_axis_act_tvalid),
    .s_axis_act_tready(s_axis_act_tready), .s_axis_act_tdata(s_axis_act_tdata),
    .array_en(array_en), .lane_data(lane_data), .lane_valid(lane_valid),
    .pass_done(pass_done), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkw(input int w);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*LANE_W +: LANE_W] = LANE_W'(32'h1000 * (k + 1) + w);
    return r;
  endfunction

  // Scoreboard: accepted lane words are queued per lane, popped when a fresh valid appears.
  logic [LANE_W-1:0] exp_q [LANES][$];
  bit sb_en = 1'b0;
  bit fresh = 1'b0;

  always @(negedge clk) begin
    if (sb_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_valid[k]) begin
          if (fresh) begin
            if (exp_q[k].size() == 0)
              chk($sformatf("lane%0d unexpected word count", k), exp_q[k].size(), 1);
            else
              chk($sformatf("lane%0d data", k), lane_data[k*LANE_W +: LANE_W], exp_q[k].pop_front());
          end
        end else begin
          chk($sformatf("lane%0d bubble zero", k), lane_data[k*LANE_W +: LANE_W], 0);
        end
      end
      if (s_axis_act_tvalid && s_axis_act_tready)
        for (int k = 0; k < LANES; k++) exp_q[k].push_back(s_axis_act_tdata[k*LANE_W +: LANE_W]);
    end
    fresh = array_en;
  end

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < LANES; k++) n += exp_q[k].size();
    return n;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input logic [LEN_W-1:0] len);
    cfg_start   = 1'b1;
    cfg_vec_len = len;
    next_cyc();
    cfg_start = 1'b0;
  endtask

  // Offers words base..base+avail-1 until the pass ends; optionally pulses cfg_start mid-pass.
  task automatic run_words(input int base, input int avail, input bit inject, output int acc, output int dn);
    int w;
    w = 0; acc = 0; dn = 0;
    for (int c = 0; c < 100; c++) begin
      s_axis_act_tvalid = (w < avail);
      s_axis_act_tdata  = mkw(base + w);
      if (inject) begin
        cfg_start   = (c == 1);
        cfg_vec_len = 1;
      end
      @(negedge clk);
      if (s_axis_act_tvalid && s_axis_act_tready) begin acc++; w++; end
      if (pass_done) dn++;
      if (!cfg_busy) break;
      next_cyc();
    end
    chk("pass end within budget", cfg_busy, 0);
    cfg_start = 1'b0;
    s_axis_act_tvalid = 1'b0;
    next_cyc();
  endtask

  typedef struct {
    bit               tvalid;
    int               word;
    bit               tready;
    logic [LANES-1:0] vld;
    bit               done;
    bit               busy;
  } vec_t;

  vec_t tbl [9];
  int   acc, dn;
  logic [DW-1:0]    snap_d;
  logic [LANES-1:0] snap_v;
  logic [LANES-1:0] ev;

  initial begin
    tbl[0] = '{1, 1, 1, 4'b0000, 0, 1};
    tbl[1] = '{1, 2, 1, 4'b0001, 0, 1};
    tbl[2] = '{1, 3, 1, 4'b0011, 0, 1};
    tbl[3] = '{0, 0, 0, 4'b0111, 0, 1};
    tbl[4] = '{0, 0, 0, 4'b1110, 0, 1};
    tbl[5] = '{0, 0, 0, 4'b1100, 0, 1};
    tbl[6] = '{0, 0, 0, 4'b1000, 0, 1};
    tbl[7] = '{0, 0, 0, 4'b0000, 1, 1};
    tbl[8] = '{0, 0, 0, 4'b0000, 0, 0};

    rst_n = 1'b0; cfg_start = 1'b0; cfg_vec_len = '0;
    s_axis_act_tvalid = 1'b0; s_axis_act_tdata = '0; array_en = 1'b1;
    next_cyc(); next_cyc();
    chk("reset busy", cfg_busy, 0);
    chk("reset tready", s_axis_act_tready, 0);
    chk("reset lane_valid", lane_valid, 0);
    chk("reset lane_data", lane_data, 0);
    chk("reset pass_done", pass_done, 0);
    chk("reset bubble_cnt", bubble_cnt, 0);
    rst_n = 1'b1;
    next_cyc();
    sb_en = 1'b1;

    // Basic pass, length 3, cycle-exact wavefront.
    start_pass(3);
    for (int r = 0; r < 9; r++) begin
      s_axis_act_tvalid = tbl[r].tvalid;
      s_axis_act_tdata  = tbl[r].tvalid ? mkw(tbl[r].word) : '0;
      @(negedge clk);
      chk($sformatf("basic r%0d tready", r), s_axis_act_tready, tbl[r].tready);
      chk($sformatf("basic r%0d lane_valid", r), lane_valid, tbl[r].vld);
      chk($sformatf("basic r%0d pass_done", r), pass_done, tbl[r].done);
      chk($sformatf("basic r%0d busy", r), cfg_busy, tbl[r].busy);
      next_cyc();
    end
    chk("basic drained", pending(), 0);

    // Two-cycle input bubble between A and B.
    start_pass(2);
    for (int r = 0; r < 9; r++) begin
      s_axis_act_tvalid = (r == 0) || (r == 3);
      s_axis_act_tdata  = mkw((r == 0) ? 10 : 11);
      @(negedge clk);
      for (int k = 0; k < LANES; k++) ev[k] = (r == k + 1) || (r == k + 4);
      chk($sformatf("bubble r%0d lane_valid", r), lane_valid, ev);
      chk($sformatf("bubble r%0d pass_done", r), pass_done, r == 8);
      if (r == 8) begin
`ifdef ACT_SKEW_BUBBLE_CNT_EN
        chk("bubble_cnt", bubble_cnt, 2);
`else
        chk("bubble_cnt", bubble_cnt, 0);
`endif
      end
      next_cyc();
    end
    s_axis_act_tvalid = 1'b0;
    next_cyc();
    chk("bubble drained", pending(), 0);

    // Five-cycle array stall after the first word; the stalled tdata must not be taken.
    start_pass(3);
    s_axis_act_tvalid = 1'b1;
    s_axis_act_tdata  = mkw(20);
    @(negedge clk);
    chk("stall first tready", s_axis_act_tready, 1);
    next_cyc();
    array_en = 1'b0;
    s_axis_act_tdata = mkw(99);
    for (int r = 1; r <= 5; r++) begin
      @(negedge clk);
      if (r == 1) begin
        snap_d = lane_data;
        snap_v = lane_valid;
      end else begin
        chk($sformatf("stall r%0d lane_data", r), lane_data, snap_d);
        chk($sformatf("stall r%0d lane_valid", r), lane_valid, snap_v);
      end
      chk($sformatf("stall r%0d tready", r), s_axis_act_tready, 0);
      next_cyc();
    end
    array_en = 1'b1;
    run_words(21, 2, 1'b0, acc, dn);
    chk("stall accepts", acc, 2);
    chk("stall pass_done count", dn, 1);
    chk("stall drained", pending(), 0);

    // Zero-length pass.
    s_axis_act_tvalid = 1'b1;
    s_axis_act_tdata  = mkw(50);
    start_pass(0);
    @(negedge clk);
    chk("zero pass_done", pass_done, 1);
    chk("zero tready", s_axis_act_tready, 0);
    chk("zero lane_valid", lane_valid, 0);
    next_cyc();
    @(negedge clk);
    chk("zero pass_done end", pass_done, 0);
    chk("zero busy end", cfg_busy, 0);
    chk("zero tready end", s_axis_act_tready, 0);
    s_axis_act_tvalid = 1'b0;
    next_cyc();

    // cfg_start during RUN is ignored.
    start_pass(3);
    run_words(60, 5, 1'b1, acc, dn);
    chk("restart ignored accepts", acc, 3);
    chk("restart ignored pass_done count", dn, 1);
    chk("restart drained", pending(), 0);

    // Reset while flushing, then a clean pass.
    start_pass(2);
    s_axis_act_tvalid = 1'b1; s_axis_act_tdata = mkw(70); next_cyc();
    s_axis_act_tdata = mkw(71); next_cyc();
    s_axis_act_tvalid = 1'b0;
    next_cyc();
    sb_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", cfg_busy, 0);
    chk("midreset lane_valid", lane_valid, 0);
    chk("midreset pass_done", pass_done, 0);
    chk("midreset lane_data", lane_data, 0);
    for (int k = 0; k < LANES; k++) exp_q[k].delete();
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    sb_en = 1'b1;
    start_pass(3);
    run_words(80, 3, 1'b0, acc, dn);
    chk("post-reset accepts", acc, 3);
    chk("post-reset pass_done count", dn, 1);
    chk("post-reset drained", pending(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
